// File: rtl/fused_pkg.sv
// Shared definitions for the fused-op path: opcodes, dispatcher state encoding and default width.
// Also imported by the fused ALU path, so keep it free of dispatcher-only logic.
package fused_pkg;

  localparam int unsigned DefaultDataW = 32;

  localparam logic [7:0] OP_FUSE_MMA_RELU  = 8'h30;
  localparam logic [7:0] OP_FUSE_CONV_RELU = 8'h31;
  localparam logic [7:0] OP_FUSE_MMA_ADD   = 8'h32;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StIssue = 2'd1;
  localparam state_t StWait  = 2'd2;
  localparam state_t StOut   = 2'd3;

  function automatic logic op_supported(logic [7:0] op);
    return (op == OP_FUSE_MMA_RELU) || (op == OP_FUSE_CONV_RELU) || (op == OP_FUSE_MMA_ADD);
  endfunction

endpackage

// File: rtl/fused_op_dispatcher_if.sv
// Handshake bundle between instruction issue, the fused-op dispatcher and the MMU/CONV units.
// master is the dispatcher side; slave is the surrounding environment.
interface fused_op_dispatcher_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_opcode;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic              mmu_req_valid;
  logic              mmu_req_ready;
  logic              conv_req_valid;
  logic              conv_req_ready;
  logic              mmu_rsp_valid;
  logic [DATA_W-1:0] mmu_rsp_data;
  logic              conv_rsp_valid;
  logic [DATA_W-1:0] conv_rsp_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;
  logic              busy;

  modport master (
    input  in_valid, in_opcode, in_a, in_b, mmu_req_ready, conv_req_ready,
           mmu_rsp_valid, mmu_rsp_data, conv_rsp_valid, conv_rsp_data, out_ready,
    output in_ready, req_a, req_b, mmu_req_valid, conv_req_valid, out_valid, out_data,
           out_err, busy
  );

  modport slave (
    output in_valid, in_opcode, in_a, in_b, mmu_req_ready, conv_req_ready,
           mmu_rsp_valid, mmu_rsp_data, conv_rsp_valid, conv_rsp_data, out_ready,
    input  in_ready, req_a, req_b, mmu_req_valid, conv_req_valid, out_valid, out_data,
           out_err, busy
  );

endinterface

// File: rtl/fused_epilogue.sv
// Combinational fused epilogue: bias-add for MMA_ADD, ReLU for every other opcode.
module fused_epilogue
  import fused_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic [7:0]        opcode_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] addend_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    if (opcode_i == OP_FUSE_MMA_ADD) begin
      result_o = data_i + addend_i;
    end else begin
      result_o = data_i[DATA_W-1] ? '0 : data_i;
    end
  end

endmodule

// File: rtl/fused_op_dispatcher.sv
// Fused-op dispatcher: issues one instruction at a time to MMU or CONV, waits for the response
// (with optional timeout), applies the fused epilogue and offers one result per instruction.
module fused_op_dispatcher
  import fused_pkg::*;
#(
  parameter int unsigned DATA_W         = DefaultDataW,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TO_W           = 11
) (
  input logic                   clk,
  input logic                   rst_n,
  fused_op_dispatcher_if.master bus
);

  localparam logic [TO_W-1:0] ToLimit = TO_W'(TIMEOUT_CYCLES);

  state_t            state_q, state_d;
  logic [7:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_err_q, out_err_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;

  logic              tgt_mmu;
  logic              req_ready_sel;
  logic              rsp_hit;
  logic [DATA_W-1:0] rsp_data;
  logic [DATA_W-1:0] epi_result;
  logic [TO_W-1:0]   cnt_inc;
  logic              timeout_hit;

  // Only supported opcodes reach ISSUE/WAIT, so anything not CONV targets the MMU.
  assign tgt_mmu       = (op_q != OP_FUSE_CONV_RELU);
  assign req_ready_sel = tgt_mmu ? bus.mmu_req_ready : bus.conv_req_ready;
  assign rsp_hit       = tgt_mmu ? bus.mmu_rsp_valid : bus.conv_rsp_valid;
  assign rsp_data      = tgt_mmu ? bus.mmu_rsp_data : bus.conv_rsp_data;
  assign cnt_inc       = cnt_q + TO_W'(1);
  assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (cnt_inc == ToLimit);

  fused_epilogue #(
    .DATA_W(DATA_W)
  ) u_epilogue (
    .opcode_i (op_q),
    .data_i   (rsp_data),
    .addend_i (b_q),
    .result_o (epi_result)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    cnt_d      = cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          op_d = bus.in_opcode;
          a_d  = bus.in_a;
          b_d  = bus.in_b;
          if (op_supported(bus.in_opcode)) begin
            state_d = StIssue;
          end else begin
            out_data_d = '0;
            out_err_d  = 1'b1;
            state_d    = StOut;
          end
        end
      end
      StIssue: begin
        if (req_ready_sel) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        // A response arriving in the timeout cycle still wins.
        if (rsp_hit) begin
          out_data_d = epi_result;
          out_err_d  = 1'b0;
          state_d    = StOut;
        end else if (timeout_hit) begin
          out_data_d = '0;
          out_err_d  = 1'b1;
          state_d    = StOut;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready       = (state_q == StIdle);
  assign bus.busy           = (state_q != StIdle);
  assign bus.mmu_req_valid  = (state_q == StIssue) && tgt_mmu;
  assign bus.conv_req_valid = (state_q == StIssue) && !tgt_mmu;
  assign bus.out_valid      = (state_q == StOut);
  assign bus.out_data       = out_data_q;
  assign bus.out_err        = out_err_q;
  assign bus.req_a          = a_q;
  assign bus.req_b          = b_q;

endmodule

// File: tb/tb_fused_op_dispatcher.sv
// Scoreboard bench for fused_op_dispatcher: expected results are queued at issue time and
// compared on each output handshake.
module tb_fused_op_dispatcher;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fused_op_dispatcher_if #(.DATA_W(DW)) bus ();

  fused_op_dispatcher #(
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (8),
    .TO_W           (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_out = 0;
  int          conv_bad = 0;
  bit          conv_allowed = 1'b0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result {err, data} for a unit response.
  function automatic logic [32:0] model(input logic [7:0] op, input logic [31:0] rsp,
                                        input logic [31:0] b);
    case (op)
      8'h30, 8'h31: return {1'b0, (rsp[31] ? 32'd0 : rsp)};
      8'h32:        return {1'b0, rsp + b};
      default:      return {1'b1, 32'd0};
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.conv_req_valid && !conv_allowed) conv_bad++;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", bus.out_data, mon_e[31:0]);
        chk("out_err", bus.out_err, mon_e[32]);
      end
      n_out++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    chk("in_ready_before_accept", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic clear_rsp();
    bus.mmu_rsp_valid  = 1'b0;
    bus.conv_rsp_valid = 1'b0;
  endtask

  // Count cycles the target request is held, grant after ready_delay cycles; optionally fire
  // junk strobes on both units in the grant cycle.
  task automatic handshake(input bit mmu, input int ready_delay, input bit junk, output int held);
    held = 0;
    for (int i = 0; i < 64; i++) begin
      chk("other_req_low", mmu ? bus.conv_req_valid : bus.mmu_req_valid, 0);
      if (mmu ? bus.mmu_req_valid : bus.conv_req_valid) begin
        held++;
        if (held > ready_delay) begin
          if (mmu) bus.mmu_req_ready = 1'b1;
          else bus.conv_req_ready = 1'b1;
          if (junk) begin
            bus.mmu_rsp_valid  = 1'b1;
            bus.mmu_rsp_data   = 32'hDEAD_BEEF;
            bus.conv_rsp_valid = 1'b1;
            bus.conv_rsp_data  = 32'hCAFE_F00D;
          end
          tick();
          bus.mmu_req_ready  = 1'b0;
          bus.conv_req_ready = 1'b0;
          clear_rsp();
          return;
        end
      end
      tick();
    end
    chk("req_never_seen", 1, 0);
  endtask

  task automatic pulse_rsp(input bit mmu, input logic [31:0] data);
    if (mmu) begin
      bus.mmu_rsp_valid = 1'b1;
      bus.mmu_rsp_data  = data;
    end else begin
      bus.conv_rsp_valid = 1'b1;
      bus.conv_rsp_data  = data;
    end
    tick();
    clear_rsp();
  endtask

  task automatic wait_out(input int target);
    for (int i = 0; i < 64; i++) begin
      if (n_out >= target) return;
      tick();
    end
    chk("out_never_seen", n_out, target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int held;
    int bad;
    bus.in_valid       = 1'b0;
    bus.in_opcode      = '0;
    bus.in_a           = '0;
    bus.in_b           = '0;
    bus.mmu_req_ready  = 1'b0;
    bus.conv_req_ready = 1'b0;
    bus.mmu_rsp_valid  = 1'b0;
    bus.mmu_rsp_data   = '0;
    bus.conv_rsp_valid = 1'b0;
    bus.conv_rsp_data  = '0;
    bus.out_ready      = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mmu_req", bus.mmu_req_valid, 0);
    chk("rst_conv_req", bus.conv_req_valid, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_req_a", bus.req_a, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;

    // MMA_RELU with negative response clamps to zero; minimum latency path.
    exp_q.push_back(model(8'h30, 32'hFFFF_FFF0, 32'd4));
    accept(8'h30, 32'd3, 32'd4);
    chk("t1_req_a", bus.req_a, 3);
    chk("t1_req_b", bus.req_b, 4);
    chk("t1_busy", bus.busy, 1);
    handshake(1'b1, 0, 1'b0, held);
    chk("t1_req_first_cycle", held, 1);
    pulse_rsp(1'b1, 32'hFFFF_FFF0);
    chk("t1_min_latency", bus.out_valid, 1);
    wait_out(1);

    // CONV_RELU with ready withheld 5 cycles; stray MMU strobe must be ignored.
    conv_allowed = 1'b1;
    exp_q.push_back(model(8'h31, 32'h0000_0123, 32'd0));
    accept(8'h31, 32'd9, 32'd0);
    handshake(1'b0, 5, 1'b0, held);
    chk("t2_req_held", held, 6);
    tick();
    pulse_rsp(1'b1, 32'h7FFF_0000);
    chk("t2_stray_ignored", bus.out_valid, 0);
    pulse_rsp(1'b0, 32'h0000_0123);
    wait_out(2);
    conv_allowed = 1'b0;

    // MMA_ADD wrap-around; strobes in the grant cycle are dropped.
    exp_q.push_back(model(8'h32, 32'hFFFF_FFF8, 32'h0000_0010));
    accept(8'h32, 32'd1, 32'h0000_0010);
    handshake(1'b1, 0, 1'b1, held);
    chk("t3_issue_strobe_dropped", bus.out_valid, 0);
    pulse_rsp(1'b1, 32'hFFFF_FFF8);
    wait_out(3);

    // Unsupported opcode: error completion the next cycle, no unit request.
    exp_q.push_back({1'b1, 32'd0});
    accept(8'h55, 32'd7, 32'd8);
    chk("t4_out_valid", bus.out_valid, 1);
    chk("t4_no_mmu_req", bus.mmu_req_valid, 0);
    chk("t4_no_conv_req", bus.conv_req_valid, 0);
    wait_out(4);

    // Timeout after 8 WAIT cycles with a stray CONV strobe along the way.
    exp_q.push_back({1'b1, 32'd0});
    accept(8'h30, 32'd0, 32'd0);
    handshake(1'b1, 0, 1'b0, held);
    for (int i = 0; i < 7; i++) begin
      if (i == 3) begin
        bus.conv_rsp_valid = 1'b1;
        bus.conv_rsp_data  = 32'd5;
      end
      tick();
      clear_rsp();
    end
    chk("t5_still_waiting", bus.out_valid, 0);
    tick();
    chk("t5_timeout_out", bus.out_valid, 1);
    wait_out(5);

    // Output back-pressure: result held stable, no new acceptance in the handshake cycle.
    bus.out_ready = 1'b0;
    exp_q.push_back(model(8'h32, 32'd7, 32'd5));
    accept(8'h32, 32'd5, 32'd5);
    handshake(1'b1, 0, 1'b0, held);
    pulse_rsp(1'b1, 32'd7);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.out_valid || bus.out_data !== 32'd12 || bus.out_err !== 1'b0 || bus.in_ready)
        bad++;
      tick();
    end
    chk("t6_hold_violations", bad, 0);
    chk("t6_in_ready_low", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_opcode = 8'h30;
    tick();
    bus.in_valid = 1'b0;
    chk("t6_not_accepted_busy", bus.busy, 0);
    chk("t6_in_ready_after", bus.in_ready, 1);
    chk("t6_out_count", n_out, 6);

    // Reset while waiting abandons the instruction; a late strobe produces nothing.
    accept(8'h30, 32'hAA, 32'hBB);
    handshake(1'b1, 0, 1'b0, held);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t7_rst_mmu_req", bus.mmu_req_valid, 0);
    chk("t7_rst_out_valid", bus.out_valid, 0);
    chk("t7_rst_busy", bus.busy, 0);
    chk("t7_rst_req_a", bus.req_a, 0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_rsp(1'b1, 32'h55);
    repeat (5) tick();
    chk("t7_no_output", n_out, 6);
    chk("t7_idle", bus.in_ready, 1);

    chk("queue_empty", exp_q.size(), 0);
    chk("conv_req_unexpected", conv_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
